shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle controller that executes V30MZ shift/rotate instructions with an arbitrary count by driving the shared ALU one single-bit step per cycle. It sits between the execution unit and the `alu` instance. The execution unit issues one request with the operand, the count and the current flags. The block iterates the ALU, then returns the shifted result and the final flags with a one-cycle `done` pulse. While it is busy, the parent routes the ALU inputs from this block's `alu_*` ports.

## Interface
Parameters: none.

- `clk  in  1`  system clock; all state changes on rising edge
- `reset  in  1`  synchronous, active-high reset
- `start  in  1`  request strobe; sampled only in IDLE
- `op  in  5`  AluOp code; one of ALUOP_ROL, ROR, ROLC, RORC, SHL, SHR, SHRA, SHLA
- `size  in  1`  0 = byte, 1 = word
- `operand  in  16`  value to shift; for byte ops only [7:0] is significant
- `count  in  8`  shift count (CL or immediate)
- `flags_in  in  6`  current flags, indexed by AluFlags
- `busy  out  1`  high whenever state != IDLE
- `done  out  1`  one-cycle pulse; result/flags_out valid in that cycle
- `result  out  16`  shifted value; held until next accepted start
- `flags_out  out  6`  final flags; held until next accepted start
- `alu_op  out  5`  ALU operation
- `alu_size  out  1`  ALU size
- `alu_a  out  16`  ALU A operand
- `alu_b  out  16`  ALU B operand
- `alu_cin  out  1`  carry into the ALU for ROLC/RORC (current CY register)
- `alu_r  in  16`  ALU result
- `alu_flags  in  6`  ALU flags

## Operation
States: IDLE, RUN, DONE.

- **Reset:** state = IDLE. `busy`, `done`, `result`, `flags_out` and all `alu_*` outputs are 0. Reset mid-RUN aborts the operation with no partial writeback.
- **IDLE, start = 1:**
  - latch `op` and `size`
  - acc <= `operand`; flg <= `flags_in`
  - cnt <= effective count (see Configuration)
  - if cnt == 0, or `op` is not a shift/rotate: go to DONE with acc and flg unchanged
  - otherwise go to RUN
- **RUN, each cycle:**
  - drive `alu_op` = op, `alu_size` = size, `alu_a` = acc, `alu_b` = 16'd1, `alu_cin` = flg[ALU_FLAG_CY]
  - acc <= `alu_r`; flg <= `alu_flags`; cnt <= cnt - 1
  - when cnt == 1, go to DONE
- **DONE:** `done` = 1, `result` = acc, `flags_out` = flg; go to IDLE next cycle.
- **Ignored starts:** `start` in RUN or DONE has no effect. The requester must wait for `busy` to fall.
- **ALU outputs outside RUN:** all `alu_*` outputs are 0.
- **Byte ops:** the upper byte of acc passes through the ALU unmodified. `result[15:8]` equals `operand[15:8]`.

## Timing
- Start is accepted at edge 0.
  - Effective count N > 0: RUN occupies cycles 1..N and `done` is high in cycle N+1.
  - N == 0: `done` is high in cycle 1.
- `busy` is high from cycle 1 through the `done` cycle inclusive. It is low in the cycle after `done`.
- A new start is accepted at the earliest in the cycle after `done`, so back-to-back throughput is N+2 cycles.
- The ALU path is combinational inside one RUN cycle. Only acc, flg, cnt and state are registered.

## Configuration
- **`SHIFT_COUNT_MASK_EN` defined:**
  - effective count = `count[4:0]` (V30MZ behaviour)
  - maximum 31 iterations; cnt register is 5 bits
- **Not defined:**
  - effective count = full 8-bit `count`
  - maximum 255 iterations; cnt register is 8 bits
- All other behaviour is identical in both builds.

## Structure
- Package `alu_pkg` holds the AluOp and AluFlags enums, shared by `alu`, this block and the execution unit.
- The state enum is local to this module.
- No sub-module. The `alu` is instantiated once by the parent and shared through the `alu_*` ports.
- The bench instantiates `shift_sequencer` together with `alu`.

## Test plan
- SHL byte, operand 0x0081, count 1 -> `done` in cycle 2, `result` 0x0002, CY = 1.
- ROR word, operand 0x0001, count 4 -> `busy` high in cycles 1..5, `done` in cycle 5, `result` 0x1000.
- SHR word, operand 0x8000, count 0, `flags_in` 0x2A -> `done` in cycle 1, `result` 0x8000, `flags_out` 0x2A, `alu_op` stays 0.
- SHL word, operand 0x0001, count 33:
  - with `SHIFT_COUNT_MASK_EN`: `result` 0x0002, `done` in cycle 2
  - without it: `result` 0x0000, `done` in cycle 34
- Start SHR word, count 8; assert `reset` in cycle 3 -> next cycle `busy` 0, `done` 0, `result` 0. A following start of SHL byte 0x0001, count 1 yields 0x0002.
- Pulse `start` in cycles 1..3 during a count-4 op -> only the first is accepted, exactly one `done` pulse occurs, and the second request is accepted only after `busy` falls.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and flag bit positions.
// Used by the alu, the shift_sequencer and the execution unit.
package alu_pkg;

  localparam int ALU_OP_W   = 5;
  localparam int ALU_FLAG_W = 6;

  // ALU operation codes; shift/rotate codes form a contiguous block
  typedef enum logic [ALU_OP_W-1:0] {
    ALUOP_ADD  = 5'd0,
    ALUOP_OR   = 5'd1,
    ALUOP_AND  = 5'd4,
    ALUOP_SUB  = 5'd5,
    ALUOP_XOR  = 5'd6,
    ALUOP_ROL  = 5'd8,
    ALUOP_ROR  = 5'd9,
    ALUOP_ROLC = 5'd10,
    ALUOP_RORC = 5'd11,
    ALUOP_SHL  = 5'd12,
    ALUOP_SHR  = 5'd13,
    ALUOP_SHLA = 5'd14,
    ALUOP_SHRA = 5'd15
  } AluOp;

  // Bit positions inside the 6-bit flags vector
  typedef enum logic [2:0] {
    ALU_FLAG_CY = 3'd0,
    ALU_FLAG_PY = 3'd1,
    ALU_FLAG_AC = 3'd2,
    ALU_FLAG_ZR = 3'd3,
    ALU_FLAG_SN = 3'd4,
    ALU_FLAG_OV = 3'd5
  } AluFlags;

endpackage

// File: rtl/shift_sequencer_pkg.sv
// Sequencer-local helpers: counter width and request decoding.
// Build option: define SHIFT_COUNT_MASK_EN to use only count[4:0]
// (V30MZ behaviour, 5-bit counter); otherwise the full 8-bit count is used.
package shift_sequencer_pkg;
  import alu_pkg::*;

`ifdef SHIFT_COUNT_MASK_EN
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 8;
`endif

  // Effective iteration count for a raw count operand
  function automatic logic [CNT_W-1:0] effCount(input logic [7:0] count);
    return count[CNT_W-1:0];
  endfunction

  // True for opcodes the sequencer iterates on
  function automatic logic isShiftOp(input logic [ALU_OP_W-1:0] op);
    case (op)
      ALUOP_ROL, ALUOP_ROR, ALUOP_ROLC, ALUOP_RORC,
      ALUOP_SHL, ALUOP_SHR, ALUOP_SHLA, ALUOP_SHRA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response and shared-ALU signals of the shift sequencer.
// slave: the sequencer's view; master: the parent (execution unit) view.
interface shift_sequencer_if;
  import alu_pkg::*;

  logic                  start;
  logic [ALU_OP_W-1:0]   op;
  logic                  size;
  logic [15:0]           operand;
  logic [7:0]            count;
  logic [ALU_FLAG_W-1:0] flags_in;
  logic                  busy;
  logic                  done;
  logic [15:0]           result;
  logic [ALU_FLAG_W-1:0] flags_out;
  logic [ALU_OP_W-1:0]   alu_op;
  logic                  alu_size;
  logic [15:0]           alu_a;
  logic [15:0]           alu_b;
  logic                  alu_cin;
  logic [15:0]           alu_r;
  logic [ALU_FLAG_W-1:0] alu_flags;

  modport slave (
    input  start, op, size, operand, count, flags_in, alu_r, alu_flags,
    output busy, done, result, flags_out, alu_op, alu_size, alu_a, alu_b, alu_cin
  );

  modport master (
    output start, op, size, operand, count, flags_in, alu_r, alu_flags,
    input  busy, done, result, flags_out, alu_op, alu_size, alu_a, alu_b, alu_cin
  );

endinterface

// File: rtl/alu.sv
// Combinational ALU shared by the execution unit and the shift sequencer.
// Shift/rotate opcodes perform exactly one single-bit step; byte ops leave
// a_i[15:8] untouched in the result.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0]   op_i,
  input  logic                  size_i,
  input  logic [15:0]           a_i,
  input  logic [15:0]           b_i,
  input  logic                  cin_i,
  output logic [15:0]           r_o,
  output logic [ALU_FLAG_W-1:0] flags_o
);

  logic [16:0] sumW, difW;
  logic [8:0]  sumB, difB;
  logic        msbA, msbB, msbR, secR;
  logic        cy, ov;
  logic [15:0] res;

  assign sumW = {1'b0, a_i} + {1'b0, b_i};
  assign difW = {1'b0, a_i} - {1'b0, b_i};
  assign sumB = {1'b0, a_i[7:0]} + {1'b0, b_i[7:0]};
  assign difB = {1'b0, a_i[7:0]} - {1'b0, b_i[7:0]};
  assign msbA = size_i ? a_i[15] : a_i[7];
  assign msbB = size_i ? b_i[15] : b_i[7];
  assign msbR = size_i ? res[15] : res[7];
  assign secR = size_i ? res[14] : res[6];

  // Result value and carry-out for each operation
  always_comb begin
    res = a_i;
    cy  = 1'b0;
    case (op_i)
      ALUOP_ADD: begin
        res = size_i ? sumW[15:0] : {a_i[15:8], sumB[7:0]};
        cy  = size_i ? sumW[16] : sumB[8];
      end
      ALUOP_SUB: begin
        res = size_i ? difW[15:0] : {a_i[15:8], difB[7:0]};
        cy  = size_i ? difW[16] : difB[8];
      end
      ALUOP_AND: res = size_i ? (a_i & b_i) : {a_i[15:8], a_i[7:0] & b_i[7:0]};
      ALUOP_OR:  res = size_i ? (a_i | b_i) : {a_i[15:8], a_i[7:0] | b_i[7:0]};
      ALUOP_XOR: res = size_i ? (a_i ^ b_i) : {a_i[15:8], a_i[7:0] ^ b_i[7:0]};
      ALUOP_ROL: begin
        res = size_i ? {a_i[14:0], a_i[15]} : {a_i[15:8], a_i[6:0], a_i[7]};
        cy  = msbA;
      end
      ALUOP_ROR: begin
        res = size_i ? {a_i[0], a_i[15:1]} : {a_i[15:8], a_i[0], a_i[7:1]};
        cy  = a_i[0];
      end
      ALUOP_ROLC: begin
        res = size_i ? {a_i[14:0], cin_i} : {a_i[15:8], a_i[6:0], cin_i};
        cy  = msbA;
      end
      ALUOP_RORC: begin
        res = size_i ? {cin_i, a_i[15:1]} : {a_i[15:8], cin_i, a_i[7:1]};
        cy  = a_i[0];
      end
      ALUOP_SHL, ALUOP_SHLA: begin
        res = size_i ? {a_i[14:0], 1'b0} : {a_i[15:8], a_i[6:0], 1'b0};
        cy  = msbA;
      end
      ALUOP_SHR: begin
        res = size_i ? {1'b0, a_i[15:1]} : {a_i[15:8], 1'b0, a_i[7:1]};
        cy  = a_i[0];
      end
      ALUOP_SHRA: begin
        res = size_i ? {a_i[15], a_i[15:1]} : {a_i[15:8], a_i[7], a_i[7:1]};
        cy  = a_i[0];
      end
      default: res = a_i;
    endcase
  end

  // Overflow: sign change for arithmetic, msb/carry disagreement for shifts
  always_comb begin
    ov = 1'b0;
    case (op_i)
      ALUOP_ADD: ov = (msbA == msbB) && (msbR != msbA);
      ALUOP_SUB: ov = (msbA != msbB) && (msbR != msbA);
      ALUOP_ROL, ALUOP_ROLC, ALUOP_SHL, ALUOP_SHLA: ov = msbR ^ cy;
      ALUOP_ROR, ALUOP_RORC: ov = msbR ^ secR;
      ALUOP_SHR: ov = msbA;
      default: ov = 1'b0;
    endcase
  end

  // Assemble the flags vector; AC is not produced by this ALU
  always_comb begin
    flags_o              = '0;
    flags_o[ALU_FLAG_CY] = cy;
    flags_o[ALU_FLAG_PY] = ~^res[7:0];
    flags_o[ALU_FLAG_ZR] = size_i ? (res == 16'd0) : (res[7:0] == 8'd0);
    flags_o[ALU_FLAG_SN] = msbR;
    flags_o[ALU_FLAG_OV] = ov;
  end

  assign r_o = res;

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: steps the shared ALU one bit per cycle
// for the requested count and returns the result with a one-cycle done pulse.
// Build option SHIFT_COUNT_MASK_EN (see shift_sequencer_pkg) masks the count to 5 bits.
module shift_sequencer
  import alu_pkg::*;
  import shift_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } SeqState;

  SeqState               state_q;
  logic [ALU_OP_W-1:0]   op_q;
  logic                  size_q;
  logic [15:0]           acc_q;
  logic [ALU_FLAG_W-1:0] flg_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic [CNT_W-1:0]      cntLoad_d;
  logic                  runActive;

  assign cntLoad_d = effCount(bus.count);
  assign runActive = (state_q == RUN);

  // Control FSM: accept a request, iterate the ALU, then present the result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      size_q  <= 1'b0;
      acc_q   <= '0;
      flg_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            size_q <= bus.size;
            acc_q  <= bus.operand;
            flg_q  <= bus.flags_in;
            cnt_q  <= cntLoad_d;
            busy_q <= 1'b1;
            if ((cntLoad_d == '0) || !isShiftOp(bus.op)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          acc_q <= bus.alu_r;
          flg_q <= bus.alu_flags;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = acc_q;
  assign bus.flags_out = flg_q;

  assign bus.alu_op   = runActive ? op_q : '0;
  assign bus.alu_size = runActive & size_q;
  assign bus.alu_a    = runActive ? acc_q : 16'd0;
  assign bus.alu_b    = runActive ? 16'd1 : 16'd0;
  assign bus.alu_cin  = runActive & flg_q[ALU_FLAG_CY];

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer driving the shared alu.
// Expected results come from an arithmetic model of repeated single-bit steps.
// Honours SHIFT_COUNT_MASK_EN the same way the design does.
module tb_shift_sequencer;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [15:0] lastRes;
  logic [5:0]  lastFlags;
  int          lastDoneCyc;

  logic [15:0] aluR;
  logic [5:0]  aluFlags;

  shift_sequencer_if bus();

  shift_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  alu aluInst (
    .op_i    (bus.alu_op),
    .size_i  (bus.alu_size),
    .a_i     (bus.alu_a),
    .b_i     (bus.alu_b),
    .cin_i   (bus.alu_cin),
    .r_o     (aluR),
    .flags_o (aluFlags)
  );

  assign bus.alu_r     = aluR;
  assign bus.alu_flags = aluFlags;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: effective count, then that many one-bit steps on a W-bit value
  function automatic void model(input logic [4:0] op, input logic size,
                                input logic [15:0] operand, input logic [7:0] count,
                                input logic [5:0] fin, output int n,
                                output logic [15:0] res, output logic [5:0] fout);
    int w, mask, top, v, nv, cy, ov, msbIn, lsb;
    logic isShift;
`ifdef SHIFT_COUNT_MASK_EN
    n = int'(count) % 32;
`else
    n = int'(count);
`endif
    isShift = (op >= ALUOP_ROL) && (op <= ALUOP_SHRA);
    if (!isShift) n = 0;
    res  = operand;
    fout = fin;
    if (n == 0) return;
    w    = size ? 16 : 8;
    mask = (1 << w) - 1;
    top  = 1 << (w - 1);
    v    = int'(operand) & mask;
    cy   = int'(fin[0]);
    ov   = 0;
    for (int i = 0; i < n; i++) begin
      msbIn = ((v & top) != 0) ? 1 : 0;
      lsb   = v & 1;
      nv    = v;
      case (op)
        ALUOP_ROL:  begin nv = ((v << 1) & mask) | msbIn;     cy = msbIn; end
        ALUOP_ROR:  begin nv = (v >> 1) | (lsb != 0 ? top : 0); cy = lsb; end
        ALUOP_ROLC: begin nv = ((v << 1) & mask) | cy;        cy = msbIn; end
        ALUOP_RORC: begin nv = (v >> 1) | (cy != 0 ? top : 0); cy = lsb;  end
        ALUOP_SHR:  begin nv = v >> 1;                        cy = lsb;   end
        ALUOP_SHRA: begin nv = (v >> 1) | (msbIn != 0 ? top : 0); cy = lsb; end
        default:    begin nv = (v << 1) & mask;               cy = msbIn; end
      endcase
      case (op)
        ALUOP_ROR, ALUOP_RORC: ov = (((nv & top) != 0) != ((nv & (top >> 1)) != 0)) ? 1 : 0;
        ALUOP_SHR:             ov = msbIn;
        ALUOP_SHRA:            ov = 0;
        default:               ov = ((((nv & top) != 0) ? 1 : 0) != cy) ? 1 : 0;
      endcase
      v = nv;
    end
    res     = size ? 16'(v) : {operand[15:8], 8'(v)};
    fout    = '0;
    fout[0] = cy[0];
    fout[1] = (($countones(v & 255) % 2) == 0);
    fout[3] = (v == 0);
    fout[4] = ((v & top) != 0);
    fout[5] = ov[0];
  endfunction

  // Issue one request at the current negedge (IDLE) and follow it to the cycle after done
  task automatic applyStimulus(input string tag, input logic [4:0] op, input logic size,
                               input logic [15:0] operand, input logic [7:0] count,
                               input logic [5:0] fin, input int extraStart);
    int          n, doneCyc, doneCount, busyBad, aluBad;
    logic [15:0] expRes, resObs;
    logic [5:0]  expFlg, flgObs;
    model(op, size, operand, count, fin, n, expRes, expFlg);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.size     = size;
    bus.operand  = operand;
    bus.count    = count;
    bus.flags_in = fin;
    doneCyc   = 0;
    doneCount = 0;
    busyBad   = 0;
    aluBad    = 0;
    resObs    = 'x;
    flgObs    = 'x;
    @(negedge clk);
    for (int cyc = 1; cyc <= n + 2; cyc++) begin
      if (cyc <= extraStart) begin
        bus.start   = 1'b1;
        bus.op      = ALUOP_SHL;
        bus.operand = ~operand;
        bus.count   = 8'd1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        doneCount++;
        if (doneCyc == 0) begin
          doneCyc = cyc;
          resObs  = bus.result;
          flgObs  = bus.flags_out;
        end
      end
      if (cyc <= n + 1 && bus.busy !== 1'b1) busyBad++;
      if (cyc == n + 2 && bus.busy !== 1'b0) busyBad++;
      if (cyc <= n && (bus.alu_op !== op || bus.alu_b !== 16'd1 || bus.alu_size !== size)) aluBad++;
      if (cyc == 1 && n > 0 && bus.alu_a !== operand) aluBad++;
      if (cyc == n + 1 && bus.alu_op !== 5'd0) aluBad++;
      if (cyc < n + 2) @(negedge clk);
    end
    bus.start = 1'b0;
    checkOutput($sformatf("%s.doneCycle", tag), doneCyc, n + 1);
    checkOutput($sformatf("%s.donePulses", tag), doneCount, 1);
    checkOutput($sformatf("%s.result", tag), resObs, expRes);
    checkOutput($sformatf("%s.flags", tag), flgObs, expFlg);
    checkOutput($sformatf("%s.busyWindow", tag), busyBad, 0);
    checkOutput($sformatf("%s.aluDrive", tag), aluBad, 0);
    lastRes     = resObs;
    lastFlags   = flgObs;
    lastDoneCyc = doneCyc;
  endtask

  logic [4:0] opList [9];

  initial begin
    total = 0;
    bad   = 0;
    opList = '{ALUOP_ROL, ALUOP_ROR, ALUOP_ROLC, ALUOP_RORC, ALUOP_SHL,
               ALUOP_SHR, ALUOP_SHLA, ALUOP_SHRA, ALUOP_ADD};
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.op       = '0;
    bus.size     = 1'b0;
    bus.operand  = '0;
    bus.count    = '0;
    bus.flags_in = '0;
    repeat (3) @(negedge clk);

    checkOutput("reset.busy", bus.busy, 0);
    checkOutput("reset.done", bus.done, 0);
    checkOutput("reset.result", bus.result, 0);
    checkOutput("reset.flags", bus.flags_out, 0);
    checkOutput("reset.aluOp", bus.alu_op, 0);
    checkOutput("reset.aluAB", {bus.alu_a, bus.alu_b}, 0);
    checkOutput("reset.aluCinSize", {bus.alu_cin, bus.alu_size}, 0);
    reset = 1'b0;

    applyStimulus("shlByte", ALUOP_SHL, 1'b0, 16'h0081, 8'd1, 6'h00, 0);
    checkOutput("shlByte.const", {lastDoneCyc[7:0], lastRes, 7'd0, lastFlags[0]}, {8'd2, 16'h0002, 8'd1});

    applyStimulus("rorWord", ALUOP_ROR, 1'b1, 16'h0001, 8'd4, 6'h00, 0);
    checkOutput("rorWord.const", {lastDoneCyc[7:0], lastRes}, {8'd5, 16'h1000});

    applyStimulus("shrZero", ALUOP_SHR, 1'b1, 16'h8000, 8'd0, 6'h2A, 0);
    checkOutput("shrZero.const", {lastDoneCyc[7:0], lastRes, 2'b00, lastFlags}, {8'd1, 16'h8000, 8'h2A});

    applyStimulus("shl33", ALUOP_SHL, 1'b1, 16'h0001, 8'd33, 6'h00, 0);
`ifdef SHIFT_COUNT_MASK_EN
    checkOutput("shl33.const", {lastDoneCyc[7:0], lastRes}, {8'd2, 16'h0002});
`else
    checkOutput("shl33.const", {lastDoneCyc[7:0], lastRes}, {8'd34, 16'h0000});
`endif

    applyStimulus("rorcByte", ALUOP_RORC, 1'b0, 16'hAB00, 8'd1, 6'h01, 0);
    checkOutput("rorcByte.const", lastRes, 16'hAB80);

    applyStimulus("nonShift", ALUOP_ADD, 1'b1, 16'h1234, 8'd5, 6'h15, 0);

    // Abort a running operation with a synchronous reset in cycle 3
    bus.start    = 1'b1;
    bus.op       = ALUOP_SHR;
    bus.size     = 1'b1;
    bus.operand  = 16'hF0F0;
    bus.count    = 8'd8;
    bus.flags_in = 6'h3F;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort.busy", bus.busy, 0);
    checkOutput("abort.done", bus.done, 0);
    checkOutput("abort.result", bus.result, 0);
    reset = 1'b0;
    applyStimulus("afterAbort", ALUOP_SHL, 1'b0, 16'h0001, 8'd1, 6'h00, 0);
    checkOutput("afterAbort.const", lastRes, 16'h0002);

    // Extra start pulses while busy must be ignored; next request follows busy falling
    applyStimulus("ignoredStart", ALUOP_ROL, 1'b1, 16'h8421, 8'd4, 6'h00, 3);
    applyStimulus("backToBack", ALUOP_SHRA, 1'b0, 16'h5A90, 8'd3, 6'h00, 0);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] cnt;
      cnt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
      applyStimulus($sformatf("rand%0d", i), opList[$urandom_range(0, 8)],
                    1'($urandom_range(0, 1)), 16'($urandom), cnt, 6'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
